// File: rtl/pattern_sequencer.sv
// Multi-mode VGA test-pattern source: colour cycling, horizontal/vertical bars and a checkerboard,
// with a per-frame animated offset. Mode changes take effect only on the falling edge of vs.
module pattern_sequencer #(
  parameter int unsigned         COLOR_W     = 6,
  parameter logic [COLOR_W-1:0]  MAX_COLOR   = 6'h3C,
  parameter int unsigned         STEP_CYCLES = 14000,
  parameter int unsigned         CNT_W       = 16,
  parameter int unsigned         BAR_SHIFT   = 5,
  parameter int unsigned         FRAME_DIV   = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic [1:0]         mode_req,
  input  logic               vs,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [COLOR_W-1:0] colorValue,
  output logic [1:0]         mode_active,
  output logic [7:0]         frame_count
);

  typedef enum logic [1:0] {
    MODE_CYCLE   = 2'd0,
    MODE_HBARS   = 2'd1,
    MODE_VBARS   = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  localparam int unsigned          DIV_W        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0]     LP_STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [DIV_W-1:0]     LP_DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [COLOR_W:0]     LP_MAX_EXT   = (COLOR_W+1)'(MAX_COLOR);
  localparam logic [COLOR_W:0]     LP_WRAP      = LP_MAX_EXT + (COLOR_W+1)'(1);

  logic               r_vs_q;
  mode_e              r_mode_active;
  logic [CNT_W-1:0]   r_step_cnt;
  logic [COLOR_W-1:0] r_base;
  logic [COLOR_W-1:0] r_frame_offset;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [7:0]         r_frame_count;
  logic [COLOR_W-1:0] r_color;

  logic               w_frame_start;
  logic [COLOR_W-1:0] w_idx;
  logic [COLOR_W:0]   w_sum;
  logic               w_checker;
  logic [COLOR_W-1:0] w_color_next;

  function automatic logic [COLOR_W-1:0] f_inc(input logic [COLOR_W-1:0] v);
    return (v == MAX_COLOR) ? '0 : v + COLOR_W'(1);
  endfunction

  assign w_frame_start = r_vs_q & ~vs;

  // Bar index fits COLOR_W bits because (1023 >> BAR_SHIFT) <= MAX_COLOR, so one subtraction wraps.
  always_comb begin
    w_idx        = '0;
    w_sum        = '0;
    w_checker    = 1'b0;
    w_color_next = '0;
    if (r_mode_active == MODE_HBARS) begin
      w_idx = COLOR_W'(DrawY >> BAR_SHIFT);
    end else begin
      w_idx = COLOR_W'(DrawX >> BAR_SHIFT);
    end
    w_sum     = (COLOR_W+1)'(r_frame_offset) + (COLOR_W+1)'(w_idx);
    w_checker = DrawX[BAR_SHIFT] ^ DrawY[BAR_SHIFT];
    case (r_mode_active)
      MODE_CYCLE:   w_color_next = r_base;
      MODE_HBARS,
      MODE_VBARS:   w_color_next = (w_sum > LP_MAX_EXT) ? COLOR_W'(w_sum - LP_WRAP)
                                                        : COLOR_W'(w_sum);
      MODE_CHECKER: w_color_next = w_checker ? (MAX_COLOR - r_frame_offset) : r_frame_offset;
      default:      w_color_next = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vs_q        <= 1'b1;
      r_mode_active <= MODE_CYCLE;
    end else begin
      r_vs_q <= vs;
      if (w_frame_start) begin
        r_mode_active <= mode_e'(mode_req);
      end
    end
  end

  // Leaving CYCLE always happens on a frame_start, where vs is low, so the vs-low clear covers it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_step_cnt     <= '0;
      r_base         <= '0;
      r_frame_offset <= '0;
      r_div_cnt      <= '0;
      r_frame_count  <= '0;
      r_color        <= '0;
    end else if (!enable) begin
      r_step_cnt     <= '0;
      r_base         <= '0;
      r_frame_offset <= '0;
      r_div_cnt      <= '0;
      r_frame_count  <= '0;
      r_color        <= '0;
    end else begin
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 8'd1;
        if (r_div_cnt == LP_DIV_LAST) begin
          r_div_cnt      <= '0;
          r_frame_offset <= f_inc(r_frame_offset);
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end
      if (r_mode_active == MODE_CYCLE) begin
        if (!vs) begin
          r_base     <= '0;
          r_step_cnt <= '0;
        end else if (r_step_cnt == LP_STEP_LAST) begin
          r_step_cnt <= '0;
          r_base     <= f_inc(r_base);
        end else begin
          r_step_cnt <= r_step_cnt + CNT_W'(1);
        end
      end
      r_color <= w_color_next;
    end
  end

  assign colorValue  = r_color;
  assign mode_active = r_mode_active;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: a small-parameter instance for colour cycling and a
// default-parameter instance for mode switching, bars, checkerboard, frame counting and reset.
module tb_pattern_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;

  logic       a_enable, a_vs;
  logic [1:0] a_mode_req;
  logic [9:0] a_x, a_y;
  logic [5:0] a_color;
  logic [1:0] a_mode_active;
  logic [7:0] a_frame_count;

  logic       b_enable, b_vs;
  logic [1:0] b_mode_req;
  logic [9:0] b_x, b_y;
  logic [5:0] b_color;
  logic [1:0] b_mode_active;
  logic [7:0] b_frame_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned exp_cycle [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};

  always #5 Clk = ~Clk;

  pattern_sequencer #(
    .COLOR_W     (6),
    .MAX_COLOR   (6'd3),
    .STEP_CYCLES (4),
    .CNT_W       (4),
    .BAR_SHIFT   (8),
    .FRAME_DIV   (1)
  ) u_dut_a (
    .Clk         (Clk),
    .Reset       (Reset),
    .enable      (a_enable),
    .mode_req    (a_mode_req),
    .vs          (a_vs),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .colorValue  (a_color),
    .mode_active (a_mode_active),
    .frame_count (a_frame_count)
  );

  pattern_sequencer u_dut_b (
    .Clk         (Clk),
    .Reset       (Reset),
    .enable      (b_enable),
    .mode_req    (b_mode_req),
    .vs          (b_vs),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .colorValue  (b_color),
    .mode_active (b_mode_active),
    .frame_count (b_frame_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    b_vs = 1'b0;
    tick();
    b_vs = 1'b1;
    tick();
  endtask

  initial begin
    Reset      = 1'b1;
    a_enable   = 1'b1;
    a_vs       = 1'b1;
    a_mode_req = 2'd0;
    a_x        = '0;
    a_y        = '0;
    b_enable   = 1'b1;
    b_vs       = 1'b1;
    b_mode_req = 2'd0;
    b_x        = '0;
    b_y        = '0;
    repeat (3) tick();

    check_eq("rst_a_color", a_color, 0);
    check_eq("rst_a_mode",  a_mode_active, 0);
    check_eq("rst_a_fc",    a_frame_count, 0);
    check_eq("rst_b_color", b_color, 0);
    check_eq("rst_b_mode",  b_mode_active, 0);
    check_eq("rst_b_fc",    b_frame_count, 0);
    Reset = 1'b0;

    // Colour cycling: each index held STEP_CYCLES=4 cycles, wrapping 3 -> 0.
    for (int k = 0; k < 17; k++) begin
      tick();
      check_eq($sformatf("cycle_%0d", k), a_color, exp_cycle[k]);
    end
    repeat (4) tick();
    check_eq("cycle_21", a_color, 1);
    a_vs = 1'b0;
    tick();
    tick();
    check_eq("cycle_vs_low", a_color, 0);
    a_enable = 1'b0;
    a_vs     = 1'b1;

    // Mid-frame mode request is deferred to the next vs fall, even with enable low.
    b_mode_req = 2'd1;
    repeat (3) tick();
    check_eq("mode_hold", b_mode_active, 0);
    b_enable = 1'b0;
    b_vs     = 1'b0;
    tick();
    check_eq("mode_switch", b_mode_active, 1);
    check_eq("dis_color", b_color, 0);
    b_vs     = 1'b1;
    b_enable = 1'b1;
    b_y      = 10'd100;
    tick();
    check_eq("hbar_y100", b_color, 3);

    // 58 frames -> frame_offset 58; HBARS add-then-wrap at MAX_COLOR=60.
    repeat (58) frame_pulse();
    check_eq("fc_58", b_frame_count, 58);
    b_y = 10'd160;
    tick();
    check_eq("hbar_y160", b_color, 2);
    b_y = 10'd0;
    tick();
    check_eq("hbar_y0", b_color, 58);
    b_y = 10'd64;
    tick();
    check_eq("hbar_y64", b_color, 60);
    b_y = 10'd96;
    tick();
    check_eq("hbar_y96", b_color, 0);
    b_y = 10'd479;
    tick();
    check_eq("hbar_y479", b_color, 11);

    // VBARS with offset 59, then offset wraps 60 -> 0.
    b_mode_req = 2'd2;
    b_x        = 10'd639;
    frame_pulse();
    check_eq("vbar_mode", b_mode_active, 2);
    check_eq("vbar_x639", b_color, 17);
    b_x = 10'd0;
    frame_pulse();
    check_eq("offset_60", b_color, 60);
    frame_pulse();
    check_eq("offset_wrap", b_color, 0);
    check_eq("fc_61", b_frame_count, 61);

    // CHECKER with offset 10.
    b_enable = 1'b0;
    tick();
    check_eq("dis_fc", b_frame_count, 0);
    b_mode_req = 2'd3;
    b_enable   = 1'b1;
    repeat (10) frame_pulse();
    check_eq("chk_mode", b_mode_active, 3);
    b_x = 10'd32;
    b_y = 10'd0;
    tick();
    check_eq("chk_32_0", b_color, 50);
    b_y = 10'd32;
    tick();
    check_eq("chk_32_32", b_color, 10);
    b_x = 10'd0;
    b_y = 10'd0;
    tick();
    check_eq("chk_0_0", b_color, 10);

    // Frame counting restarts after enable toggles.
    b_enable = 1'b0;
    tick();
    b_enable = 1'b1;
    repeat (5) frame_pulse();
    check_eq("fc_5", b_frame_count, 5);
    b_enable = 1'b0;
    tick();
    check_eq("fc_cleared", b_frame_count, 0);
    b_enable = 1'b1;
    tick();
    check_eq("fc_no_frame", b_frame_count, 0);
    frame_pulse();
    check_eq("fc_restart", b_frame_count, 1);
    check_eq("pre_rst_color", b_color, 1);
    check_eq("pre_rst_mode", b_mode_active, 3);

    // Asynchronous reset away from any clock edge.
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_eq("arst_color", b_color, 0);
    check_eq("arst_mode",  b_mode_active, 0);
    check_eq("arst_fc",    b_frame_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
